// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_e;

  // 12 MHz system clock / 115200 baud
  localparam int CLKS_PER_BIT_DEF = 104;

  // Level the serial line rests at between frames
  localparam logic TX_IDLE = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side bundle: the transmitter (master) strobes pop, the FIFO
// (slave) supplies empty and data_out.
interface fifo_uart_tx_if;
  logic       empty;
  logic [7:0] fifo_data;
  logic       pop;

  modport master (input empty, input fifo_data, output pop);
  modport slave  (output empty, output fifo_data, input pop);
endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, tick marks the last cycle.
module uart_baud_counter
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Free-run within a bit, wrap on the bit boundary, hold at zero while cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      cnt <= '0;
    else if (clear || cnt == LAST)  cnt <= '0;
    else                            cnt <= cnt + CNT_W'(1);
  end

  assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains one byte per frame from the FIFO and sends it as 8N1 on tx.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  fifo_uart_tx_if.master        fifo,
  output logic                  tx,
  output logic                  busy
);

  tx_state_e  state_q, state_n;
  logic [7:0] shift_q, shift_n;
  logic [2:0] idx_q, idx_n;
  logic       pop_q, pop_n;
  logic       tx_n, busy_n;
  logic       tick, clear;

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .tick  (tick)
  );

  assign fifo.pop = pop_q;

  // State, datapath and registered outputs; reset forces the line idle at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      pop_q   <= 1'b0;
      tx      <= TX_IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_n;
      shift_q <= shift_n;
      idx_q   <= idx_n;
      pop_q   <= pop_n;
      tx      <= tx_n;
      busy    <= busy_n;
    end
  end

  // Next state and next output values; the byte is shifted out LSB first
  always_comb begin
    state_n = state_q;
    shift_n = shift_q;
    idx_n   = idx_q;
    tx_n    = tx;
    pop_n   = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        tx_n  = TX_IDLE;
        clear = 1'b1;
        if (!fifo.empty) begin
          state_n = POP;
          pop_n   = 1'b1;
        end
      end
      POP: begin
        // FIFO registers the pop on this edge; data is valid next cycle
        clear   = 1'b1;
        state_n = LOAD;
      end
      LOAD: begin
        clear   = 1'b1;
        shift_n = fifo.fifo_data;
        idx_n   = '0;
        tx_n    = 1'b0;
        state_n = START;
      end
      START: begin
        if (tick) begin
          tx_n    = shift_q[0];
          shift_n = {1'b0, shift_q[7:1]};
          state_n = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == 3'd7) begin
            tx_n    = TX_IDLE;
            state_n = STOP;
          end else begin
            tx_n    = shift_q[0];
            shift_n = {1'b0, shift_q[7:1]};
            idx_n   = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: two transmitters (4 and 2 clocks per bit) fed by small FIFO models.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx4, busy4, tx2, busy2;

  always #5 clk = ~clk;

  fifo_uart_tx_if b4();
  fifo_uart_tx_if b2();

  fifo_uart_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .reset(reset), .fifo(b4.master), .tx(tx4), .busy(busy4)
  );
  fifo_uart_tx #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .reset(reset), .fifo(b2.master), .tx(tx2), .busy(busy2)
  );

  // FIFO models: registered data_out on the pop edge, underflow counted
  logic [7:0] mem4 [32];
  logic [7:0] mem2 [32];
  int wr4 = 0, rd4 = 0, uf4 = 0;
  int wr2 = 0, rd2 = 0, uf2 = 0;

  assign b4.empty = (wr4 == rd4);
  assign b2.empty = (wr2 == rd2);

  always @(posedge clk) begin
    if (b4.pop) begin
      if (wr4 == rd4) uf4 <= uf4 + 1;
      else begin
        b4.fifo_data <= mem4[rd4];
        rd4 <= rd4 + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (b2.pop) begin
      if (wr2 == rd2) uf2 <= uf2 + 1;
      else begin
        b2.fifo_data <= mem2[rd2];
        rd2 <= rd2 + 1;
      end
    end
  end

  // Which DUT the shared tasks look at
  int   sel = 0;
  logic cur_tx, cur_pop, cur_busy;
  always_comb begin
    cur_tx   = (sel != 0) ? tx2     : tx4;
    cur_pop  = (sel != 0) ? b2.pop  : b4.pop;
    cur_busy = (sel != 0) ? busy2   : busy4;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    if (sel != 0) begin mem2[wr2] = d; wr2++; end
    else          begin mem4[wr4] = d; wr4++; end
  endtask

  task automatic wait_pop(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!cur_pop && n < 100);
    chk("pop_seen", 32'(cur_pop), 1);
  endtask

  // Entered right after pop was sampled high; checks LOAD, 10 bit slots and the following IDLE cycle
  task automatic frame(input logic [7:0] b, input bit last, input int push_at, input logic [7:0] pb);
    int   cpb;
    int   k;
    logic exp;
    cpb = (sel != 0) ? 2 : 4;
    step();
    chk("load_pop", 32'(cur_pop), 0);
    chk("load_tx", 32'(cur_tx), 1);
    chk("load_busy", 32'(cur_busy), 1);
    for (int i = 0; i < 10 * cpb; i++) begin
      step();
      k = i / cpb;
      exp = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      chk("bit", 32'(cur_tx), 32'(exp));
      chk("nopop", 32'(cur_pop), 0);
      chk("busy", 32'(cur_busy), 1);
      if (i == push_at) push(pb);
    end
    step();
    chk("idle_tx", 32'(cur_tx), 1);
    chk("idle_pop", 32'(cur_pop), 0);
    if (last) chk("busy_end", 32'(cur_busy), 0);
  endtask

  int n;

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_tx4", 32'(tx4), 1);
    chk("rst_pop4", 32'(b4.pop), 0);
    chk("rst_busy4", 32'(busy4), 0);
    chk("rst_tx2", 32'(tx2), 1);
    chk("rst_busy2", 32'(busy2), 0);
    reset = 1'b0;

    // Empty FIFO: line stays idle
    for (int i = 0; i < 100; i++) begin
      step();
      chk("empty_tx", 32'(tx4), 1);
      chk("empty_pop", 32'(b4.pop), 0);
      chk("empty_busy", 32'(busy4), 0);
    end
    chk("empty_rd", rd4, 0);

    // Single byte 0xA5
    push(8'hA5);
    wait_pop(n);
    chk("a5_lat", n, 1);
    frame(8'hA5, 1'b1, -1, 8'h00);
    repeat (10) step();
    chk("a5_pops", rd4, 1);

    // Three bytes back to back
    push(8'h00); push(8'hFF); push(8'h3C);
    wait_pop(n);  chk("b2b_lat0", n, 1);
    frame(8'h00, 1'b0, -1, 8'h00);
    wait_pop(n);  chk("b2b_lat1", n, 1);
    frame(8'hFF, 1'b0, -1, 8'h00);
    wait_pop(n);  chk("b2b_lat2", n, 1);
    frame(8'h3C, 1'b1, -1, 8'h00);
    repeat (20) begin
      step();
      chk("b2b_nopop", 32'(b4.pop), 0);
    end
    chk("b2b_pops", rd4, 4);

    // Byte arrives while a frame is in DATA
    push(8'h5A);
    wait_pop(n);  chk("mid_lat0", n, 1);
    frame(8'h5A, 1'b0, 10, 8'h6B);
    wait_pop(n);  chk("mid_lat1", n, 1);
    frame(8'h6B, 1'b1, -1, 8'h00);
    chk("mid_pops", rd4, 6);

    // Reset in the middle of data bit 3 of 0xC3
    push(8'hC3); push(8'h96);
    wait_pop(n);  chk("rst_lat0", n, 1);
    step();
    repeat (18) step();
    chk("pre_rst_tx", 32'(tx4), 0);
    reset = 1'b1;
    #1;
    chk("async_tx", 32'(tx4), 1);
    chk("async_pop", 32'(b4.pop), 0);
    chk("async_busy", 32'(busy4), 0);
    repeat (3) begin
      step();
      chk("rst_hold_pop", 32'(b4.pop), 0);
    end
    chk("rst_pops", rd4, 7);
    reset = 1'b0;
    wait_pop(n);  chk("rst_lat1", n, 1);
    frame(8'h96, 1'b1, -1, 8'h00);
    chk("rst_pops2", rd4, 8);
    chk("uf4", uf4, 0);

    // Minimum bit period, byte 0x81
    sel = 1;
    push(8'h81);
    wait_pop(n);  chk("cpb2_lat", n, 1);
    frame(8'h81, 1'b1, -1, 8'h00);
    chk("cpb2_pops", rd2, 1);
    chk("uf2", uf2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
